// File: rtl/cdb_arbiter_if.sv
// Common Data Bus interface: functional-unit result handshake plus the
// registered CDB broadcast. The arbiter uses the slave side; producers and
// consumers (or a bench) use the master side.
interface cdb_arbiter_if #(
  parameter int NUM_FU = 4,
  parameter int ROB_W  = 3,
  parameter int DATA_W = 32,
  parameter int SRC_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
);
  logic                              flush;
  logic [NUM_FU-1:0]                 fu_valid;
  logic [NUM_FU-1:0][ROB_W-1:0]      fu_rob;
  logic [NUM_FU-1:0][DATA_W-1:0]     fu_data;
  logic [NUM_FU-1:0]                 fu_ready;
  logic                              cdb_en;
  logic [ROB_W-1:0]                  cdb_rob_entry;
  logic [DATA_W-1:0]                 cdb_rd_data;
  logic [SRC_W-1:0]                  cdb_src;

  modport slave (
    input  flush, fu_valid, fu_rob, fu_data,
    output fu_ready, cdb_en, cdb_rob_entry, cdb_rd_data, cdb_src
  );

  modport master (
    output flush, fu_valid, fu_rob, fu_data,
    input  fu_ready, cdb_en, cdb_rob_entry, cdb_rd_data, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding slot per functional unit, a round-robin grant of
// one held result per cycle, and a registered broadcast onto the CDB.
// A slot is never captured and granted on the same edge, so fu_ready comes
// straight from the held flags with no path from fu_valid.
module cdb_arbiter #(
  parameter int NUM_FU    = 4,
  parameter int ROB_DEPTH = 8,
  parameter int DATA_W    = 32
) (
  input  logic          clk,
  input  logic          rst,
  cdb_arbiter_if.slave  bus
);
  localparam int ROB_W = $clog2(ROB_DEPTH);
  localparam int SRC_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0]             held_q, held_d;
  logic [NUM_FU-1:0][ROB_W-1:0]  tag_q;
  logic [NUM_FU-1:0][DATA_W-1:0] data_q;
  logic [SRC_W-1:0]              rr_q, rr_d;
  logic                          cdb_en_q, cdb_en_d;
  logic [ROB_W-1:0]              cdb_rob_q, cdb_rob_d;
  logic [DATA_W-1:0]             cdb_data_q, cdb_data_d;
  logic [SRC_W-1:0]              cdb_src_q, cdb_src_d;

  logic [NUM_FU-1:0]             take;
  logic                          found;
  logic [SRC_W-1:0]              win;
  logic [SRC_W-1:0]              idx;

  // A free slot accepts whatever its unit presents, unless a flush is in flight.
  assign take = bus.fu_valid & ~held_q & {NUM_FU{~bus.flush}};

  assign bus.fu_ready      = ~held_q;
  assign bus.cdb_en        = cdb_en_q;
  assign bus.cdb_rob_entry = cdb_rob_q;
  assign bus.cdb_rd_data   = cdb_data_q;
  assign bus.cdb_src       = cdb_src_q;

  // Round-robin search: first held slot at or after rr_q, wrapping modulo NUM_FU.
  always_comb begin
    found = 1'b0;
    win   = rr_q;
    idx   = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = SRC_W'((int'(rr_q) + k) % NUM_FU);
      if (!found && held_q[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Next state: flush wipes the slots; otherwise grant the winner and fill free slots.
  always_comb begin
    held_d     = held_q;
    rr_d       = rr_q;
    cdb_en_d   = 1'b0;
    cdb_rob_d  = cdb_rob_q;
    cdb_data_d = cdb_data_q;
    cdb_src_d  = cdb_src_q;
    if (bus.flush) begin
      held_d = '0;
    end else begin
      if (found) begin
        held_d[win] = 1'b0;
        cdb_en_d    = 1'b1;
        cdb_rob_d   = tag_q[win];
        cdb_data_d  = data_q[win];
        cdb_src_d   = win;
        rr_d        = (win == SRC_W'(NUM_FU - 1)) ? '0 : win + 1'b1;
      end
      held_d = held_d | take;
    end
  end

  // Control and broadcast registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      held_q     <= '0;
      rr_q       <= '0;
      cdb_en_q   <= 1'b0;
      cdb_rob_q  <= '0;
      cdb_data_q <= '0;
      cdb_src_q  <= '0;
    end else begin
      held_q     <= held_d;
      rr_q       <= rr_d;
      cdb_en_q   <= cdb_en_d;
      cdb_rob_q  <= cdb_rob_d;
      cdb_data_q <= cdb_data_d;
      cdb_src_q  <= cdb_src_d;
    end
  end

  // Slot payload: latched on capture only; validity is tracked by held_q.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (take[i]) begin
        tag_q[i]  <= bus.fu_rob[i];
        data_q[i] <= bus.fu_data[i];
      end
    end
  end
endmodule
